spart_driver: RTL and testbench
===============================

SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
- clk  input  1  system clock (100 MHz); all logic is rising-edge.
- rst  input  1  synchronous, active-low reset.
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- rda  input  1  SPART receive-data-available.
- tbr  input  1  SPART transmit-buffer-ready.
- iocs  output  1  SPART chip select.
- iorw  output  1  1=read, 0=write.
- ioaddr  output  2  00=RX/TX buffer, 01=status, 10=DB_LOW, 11=DB_HIGH.
- databus  inout  8  shared SPART data bus.
- last_rx  output  8  most recent byte read from the SPART.

Function
REQ-002 The divisor table SHALL be: br_cfg 00->16'h0515, 01->16'h028A, 10->16'h0145, 11->16'h00A2.
REQ-003 The FSM states SHALL be LOAD_LO, LOAD_HI, WAIT_RX, READ_RX, WAIT_TX and WRITE_TX.
REQ-004 Outputs SHALL be registered and decoded from the state, changing only on clk rising edges.
REQ-005 LOAD_LO (1 cycle): iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next state LOAD_HI.
REQ-006 LOAD_HI (1 cycle): iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; next state WAIT_RX.
REQ-007 WAIT_RX: iocs=0; on rda=1 go to READ_RX, or to LOAD_LO if reprog=1 (reprog has priority over rda).
REQ-008 READ_RX (1 cycle): iocs=1, iorw=1, ioaddr=00; databus is sampled into the rx_byte and last_rx registers at the end of the cycle; next state WAIT_TX.
REQ-009 WAIT_TX: iocs=0; on tbr=1 go to WRITE_TX.
REQ-010 WRITE_TX (1 cycle): iocs=1, iorw=0, ioaddr=00, databus=tx_byte; next state WAIT_RX.
REQ-011 databus SHALL be driven only when iocs=1 and iorw=0, and SHALL be high-Z otherwise.
REQ-012 When iocs=0, iorw=1 and ioaddr=00.
REQ-013 Latency: with rda first sampled high in WAIT_RX at edge N and tbr held high, READ_RX SHALL be at cycle N+1, WAIT_TX at N+2 and WRITE_TX at N+3.
REQ-014 br_cfg SHALL be registered every cycle as br_cfg_q.
REQ-015 Any cycle where br_cfg != br_cfg_q SHALL set the reprog flag; LOAD_LO entry clears reprog.
REQ-016 A br_cfg change in READ_RX, WAIT_TX or WRITE_TX SHALL NOT abort the echo; reprogramming occurs at the next WAIT_RX.
REQ-017 The divisor SHALL be taken from br_cfg_q in LOAD_LO/LOAD_HI, so LO and HI always come from the same entry.
REQ-018 rda asserted in WAIT_TX SHALL be ignored until the FSM returns to WAIT_RX; no byte is dropped by the driver.
REQ-019 tbr in any state other than WAIT_TX SHALL have no effect.

Reset
REQ-020 While rst=0 at a clk edge: state=LOAD_LO (entered after release), iocs=0, iorw=1, ioaddr=00, databus=Z, last_rx=8'h00, rx_byte=8'h00, reprog=0, br_cfg_q=br_cfg.
REQ-021 The first cycle after rst deasserts SHALL be LOAD_LO.
REQ-022 Reset asserted mid-operation (any state) SHALL abandon the transaction and release the bus in the same edge.

Configuration
REQ-023 Macro SPART_DRV_UPCASE_EN: when defined, tx_byte SHALL be rx_byte-8'h20 if rx_byte is in 8'h61..8'h7A, else rx_byte.
REQ-024 When SPART_DRV_UPCASE_EN is undefined, tx_byte SHALL be rx_byte; last_rx is unconverted in both builds.

Verification
REQ-025 Reset release with br_cfg=01 -> the next two cycles SHALL be iocs=1, iorw=0, ioaddr=10 with databus=8'h8A, then ioaddr=11 with databus=8'h02, then iocs=0.
REQ-026 rda pulse with the bench driving 8'hA5 during the read and tbr=1 -> read at N+1, write at N+3 with databus=8'hA5, and last_rx=8'hA5.
REQ-027 rda with 8'hE7 and tbr held 0 for 50 cycles -> the FSM holds WAIT_TX with iocs=0; the write of 8'hE7 occurs one cycle after tbr rises.
REQ-028 br_cfg 01->11 while in WAIT_TX with 8'h24 pending -> 8'h24 is written first, then LOAD_LO/LOAD_HI write 8'hA2 then 8'h00.
REQ-029 With SPART_DRV_UPCASE_EN defined, an rx of 8'h61 -> a tx of 8'h41; with it undefined -> a tx of 8'h61; an rx of 8'h7B -> a tx of 8'h7B in both builds.
REQ-030 rst=0 asserted during READ_RX -> at the next edge iocs=0 and databus=Z, last_rx=8'h00, then LOAD_LO after release.

Source files
------------

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor, then echoes every received
// byte back to the transmitter. The divisor is reloaded whenever br_cfg changes,
// but only once any echo already in progress has finished.
// Optional build macro: SPART_DRV_UPCASE_EN converts lower-case ASCII to
// upper case on the transmit path. last_rx always holds the unconverted byte.
module spart_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_rx
);

  typedef enum logic [2:0] {
    LOAD_LO,
    LOAD_HI,
    WAIT_RX,
    READ_RX,
    WAIT_TX,
    WRITE_TX
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        running;
  logic [1:0]  br_cfg_q;
  logic        reprog;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [15:0] divisor;
  logic [7:0]  div_hi_q;
  logic [7:0]  bus_out;
  logic        bus_oe;

  logic        nx_iocs;
  logic        nx_iorw;
  logic [1:0]  nx_addr;
  logic [7:0]  nx_data;
  logic        nx_oe;

  // The driver puts data on the bus only while it is writing to the SPART.
  assign databus = bus_oe ? bus_out : 'z;

  // Divisor lookup for the registered baud select.
  always_comb begin
    divisor = 16'h0515;
    case (br_cfg_q)
      2'b00:   divisor = 16'h0515;
      2'b01:   divisor = 16'h028A;
      2'b10:   divisor = 16'h0145;
      2'b11:   divisor = 16'h00A2;
      default: divisor = 16'h0515;
    endcase
  end

  // Transmit byte derived from the last received byte.
  always_comb begin
    tx_byte = rx_byte;
`ifdef SPART_DRV_UPCASE_EN
    if (rx_byte >= 8'h61 && rx_byte <= 8'h7A) begin
      tx_byte = rx_byte - 8'h20;
    end
`endif
  end

  // Next-state logic. After reset the FSM sits in LOAD_LO with the bus idle
  // for one edge, so that the first active cycle after release is LOAD_LO.
  always_comb begin
    next_state = state;
    if (!running) begin
      next_state = LOAD_LO;
    end else begin
      case (state)
        LOAD_LO:  next_state = LOAD_HI;
        LOAD_HI:  next_state = WAIT_RX;
        WAIT_RX: begin
          if (reprog) begin
            next_state = LOAD_LO;
          end else if (rda) begin
            next_state = READ_RX;
          end
        end
        READ_RX:  next_state = WAIT_TX;
        WAIT_TX: begin
          if (tbr) begin
            next_state = WRITE_TX;
          end
        end
        WRITE_TX: next_state = WAIT_RX;
        default:  next_state = LOAD_LO;
      endcase
    end
  end

  // Bus controls for the state being entered; registered at the same edge as
  // the state so the outputs always match the current state.
  always_comb begin
    nx_iocs = 1'b0;
    nx_iorw = 1'b1;
    nx_addr = 2'b00;
    nx_data = '0;
    nx_oe   = 1'b0;
    case (next_state)
      LOAD_LO: begin
        nx_iocs = 1'b1;
        nx_iorw = 1'b0;
        nx_addr = 2'b10;
        nx_data = divisor[7:0];
        nx_oe   = 1'b1;
      end
      LOAD_HI: begin
        nx_iocs = 1'b1;
        nx_iorw = 1'b0;
        nx_addr = 2'b11;
        nx_data = div_hi_q;
        nx_oe   = 1'b1;
      end
      READ_RX: begin
        nx_iocs = 1'b1;
        nx_iorw = 1'b1;
        nx_addr = 2'b00;
      end
      WRITE_TX: begin
        nx_iocs = 1'b1;
        nx_iorw = 1'b0;
        nx_addr = 2'b00;
        nx_data = tx_byte;
        nx_oe   = 1'b1;
      end
      default: begin
        nx_iocs = 1'b0;
        nx_iorw = 1'b1;
        nx_addr = 2'b00;
      end
    endcase
  end

  // State register and registered bus controls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= LOAD_LO;
      running <= 1'b0;
      iocs    <= 1'b0;
      iorw    <= 1'b1;
      ioaddr  <= 2'b00;
      bus_out <= '0;
      bus_oe  <= 1'b0;
    end else begin
      state   <= next_state;
      running <= 1'b1;
      iocs    <= nx_iocs;
      iorw    <= nx_iorw;
      ioaddr  <= nx_addr;
      bus_out <= nx_data;
      bus_oe  <= nx_oe;
    end
  end

  // High divisor byte is captured together with the low byte on LOAD_LO
  // entry, so both halves always come from the same table entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_hi_q <= '0;
    end else if (next_state == LOAD_LO) begin
      div_hi_q <= divisor[15:8];
    end
  end

  // Baud select tracking; a new change wins over the clear on LOAD_LO entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cfg_q <= br_cfg;
      reprog   <= 1'b0;
    end else begin
      br_cfg_q <= br_cfg;
      if (br_cfg != br_cfg_q) begin
        reprog <= 1'b1;
      end else if (next_state == LOAD_LO) begin
        reprog <= 1'b0;
      end
    end
  end

  // Capture the received byte at the end of the READ_RX cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_byte <= '0;
      last_rx <= '0;
    end else if (state == READ_RX) begin
      rx_byte <= databus;
      last_rx <= databus;
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Directed testbench for spart_driver: divisor load, echo, transmit stall,
// baud reprogramming, optional upper-case conversion and mid-operation reset.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] last_rx;
  logic [7:0] rx_val = 8'h00;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0] up_rx  [5] = '{8'h61, 8'h7A, 8'h7B, 8'h60, 8'h41};
`ifdef SPART_DRV_UPCASE_EN
  logic [7:0] up_exp [5] = '{8'h41, 8'h5A, 8'h7B, 8'h60, 8'h41};
`else
  logic [7:0] up_exp [5] = '{8'h61, 8'h7A, 8'h7B, 8'h60, 8'h41};
`endif

  always #5 clk = ~clk;

  // SPART model: places the receive byte on the bus during a read cycle.
  assign databus = (iocs && iorw) ? rx_val : 8'hzz;

  spart_driver dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .rda     (rda),
    .tbr     (tbr),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .last_rx (last_rx)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    br_cfg = 2'b01;
    repeat (3) step();
    total++; if (iocs !== 1'b0) $display("FAIL rst_iocs: got %0b expected 0", iocs); else passed++;
    total++; if (iorw !== 1'b1) $display("FAIL rst_iorw: got %0b expected 1", iorw); else passed++;
    total++; if (ioaddr !== 2'b00) $display("FAIL rst_ioaddr: got %0b expected 00", ioaddr); else passed++;
    total++; if (last_rx !== 8'h00) $display("FAIL rst_last_rx: got %h expected 00", last_rx); else passed++;
  endtask

  task automatic test_divisor_load;
    rst = 1'b1;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1010) $display("FAIL lo_ctrl: got %b expected 1010", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'h8A) $display("FAIL lo_data: got %h expected 8a", databus); else passed++;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1011) $display("FAIL hi_ctrl: got %b expected 1011", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'h02) $display("FAIL hi_data: got %h expected 02", databus); else passed++;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b0100) $display("FAIL load_idle: got %b expected 0100", {iocs, iorw, ioaddr}); else passed++;
  endtask

  task automatic test_echo;
    rx_val = 8'hA5;
    rda = 1'b1;
    tbr = 1'b1;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1100) $display("FAIL echo_read: got %b expected 1100", {iocs, iorw, ioaddr}); else passed++;
    rda = 1'b0;
    step();
    total++; if (iocs !== 1'b0) $display("FAIL echo_wait_tx: got iocs %0b expected 0", iocs); else passed++;
    total++; if (last_rx !== 8'hA5) $display("FAIL echo_last_rx: got %h expected a5", last_rx); else passed++;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1000) $display("FAIL echo_write: got %b expected 1000", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'hA5) $display("FAIL echo_data: got %h expected a5", databus); else passed++;
    step();
    total++; if (iocs !== 1'b0) $display("FAIL echo_back_rx: got iocs %0b expected 0", iocs); else passed++;
    step();
    total++; if (iocs !== 1'b0) $display("FAIL echo_tbr_ignored: got iocs %0b expected 0", iocs); else passed++;
    tbr = 1'b0;
  endtask

  task automatic test_tbr_stall;
    int unsigned bad;
    bad = 0;
    rx_val = 8'hE7;
    rda = 1'b1;
    step();
    rda = 1'b0;
    step();
    rda = 1'b1;
    rx_val = 8'h33;
    for (int i = 0; i < 50; i++) begin
      step();
      if (iocs !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL stall_iocs: got %0d active cycles expected 0", bad); else passed++;
    total++; if (last_rx !== 8'hE7) $display("FAIL stall_last_rx: got %h expected e7", last_rx); else passed++;
    tbr = 1'b1;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1000) $display("FAIL stall_write: got %b expected 1000", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'hE7) $display("FAIL stall_data: got %h expected e7", databus); else passed++;
    tbr = 1'b0;
    step();
    total++; if (iocs !== 1'b0) $display("FAIL stall_back_rx: got iocs %0b expected 0", iocs); else passed++;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1100) $display("FAIL held_rda_read: got %b expected 1100", {iocs, iorw, ioaddr}); else passed++;
    rda = 1'b0;
    step();
    total++; if (last_rx !== 8'h33) $display("FAIL held_rda_last_rx: got %h expected 33", last_rx); else passed++;
    tbr = 1'b1;
    step();
    total++; if (databus !== 8'h33) $display("FAIL held_rda_data: got %h expected 33", databus); else passed++;
    tbr = 1'b0;
    step();
  endtask

  task automatic test_reprog;
    rx_val = 8'h24;
    rda = 1'b1;
    step();
    rda = 1'b0;
    step();
    br_cfg = 2'b11;
    step();
    step();
    total++; if (iocs !== 1'b0) $display("FAIL reprog_hold: got iocs %0b expected 0", iocs); else passed++;
    tbr = 1'b1;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1000) $display("FAIL reprog_write: got %b expected 1000", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'h24) $display("FAIL reprog_data: got %h expected 24", databus); else passed++;
    tbr = 1'b0;
    step();
    total++; if (iocs !== 1'b0) $display("FAIL reprog_wait_rx: got iocs %0b expected 0", iocs); else passed++;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1010) $display("FAIL reprog_lo_ctrl: got %b expected 1010", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'hA2) $display("FAIL reprog_lo_data: got %h expected a2", databus); else passed++;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1011) $display("FAIL reprog_hi_ctrl: got %b expected 1011", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'h00) $display("FAIL reprog_hi_data: got %h expected 00", databus); else passed++;
    step();
    total++; if (iocs !== 1'b0) $display("FAIL reprog_idle: got iocs %0b expected 0", iocs); else passed++;
  endtask

  task automatic test_upcase;
    for (int i = 0; i < 5; i++) begin
      rx_val = up_rx[i];
      rda = 1'b1;
      step();
      rda = 1'b0;
      step();
      tbr = 1'b1;
      step();
      total++; if (databus !== up_exp[i]) $display("FAIL upcase_tx[%0d]: got %h expected %h", i, databus, up_exp[i]); else passed++;
      total++; if (last_rx !== up_rx[i]) $display("FAIL upcase_last_rx[%0d]: got %h expected %h", i, last_rx, up_rx[i]); else passed++;
      tbr = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid;
    rx_val = 8'h5C;
    rda = 1'b1;
    step();
    rda = 1'b0;
    total++; if ({iocs, iorw, ioaddr} !== 4'b1100) $display("FAIL mid_pre_read: got %b expected 1100", {iocs, iorw, ioaddr}); else passed++;
    rst = 1'b0;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b0100) $display("FAIL mid_rst_ctrl: got %b expected 0100", {iocs, iorw, ioaddr}); else passed++;
    total++; if (last_rx !== 8'h00) $display("FAIL mid_rst_last_rx: got %h expected 00", last_rx); else passed++;
    rst = 1'b1;
    step();
    total++; if ({iocs, iorw, ioaddr} !== 4'b1010) $display("FAIL mid_lo_ctrl: got %b expected 1010", {iocs, iorw, ioaddr}); else passed++;
    total++; if (databus !== 8'hA2) $display("FAIL mid_lo_data: got %h expected a2", databus); else passed++;
    step();
    total++; if (databus !== 8'h00) $display("FAIL mid_hi_data: got %h expected 00", databus); else passed++;
    step();
    total++; if (iocs !== 1'b0) $display("FAIL mid_idle: got iocs %0b expected 0", iocs); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_divisor_load();
    test_echo();
    test_tbr_stall();
    test_reprog();
    test_upcase();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
